// File: rtl/passwd_checker.sv
// passwd_checker: keypad entry checker against a six-digit stored password.
// Digits are compared in order as they arrive; the result stays hidden until
// enter. A correct entry gives a timed unlock. MAX_TRIES consecutive
// rejections give a timed alarm lockout.
module passwd_checker #(
  parameter int MAX_TRIES     = 3,
  parameter int UNLOCK_CYCLES = 16,
  parameter int ALARM_CYCLES  = 32
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  input  logic       enter,
  input  logic       cancel,
  input  logic [3:0] q1,
  input  logic [3:0] q2,
  input  logic [3:0] q3,
  input  logic [3:0] q4,
  input  logic [3:0] q5,
  input  logic [3:0] q6,
  output logic       unlock,
  output logic       fail,
  output logic       alarm,
  output logic [2:0] digit_cnt,
  output logic [2:0] err_cnt
);

  localparam int TMAX = (UNLOCK_CYCLES > ALARM_CYCLES) ? UNLOCK_CYCLES : ALARM_CYCLES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [2:0] MAX_T = 3'(MAX_TRIES);

  typedef enum logic [2:0] {IDLE, ENTRY, OPEN, FAIL, ALARM} state_t;

  state_t          state, state_n;
  logic            mismatch, mism_n;
  logic [2:0]      digit_n, err_n, err_inc;
  logic [TW-1:0]   timer, timer_n;
  logic [3:0]      exp_digit;

  // Stored digit that the next keyed digit is compared against.
  always_comb begin
    case (digit_cnt)
      3'd0:    exp_digit = q1;
      3'd1:    exp_digit = q2;
      3'd2:    exp_digit = q3;
      3'd3:    exp_digit = q4;
      3'd4:    exp_digit = q5;
      default: exp_digit = q6;
    endcase
  end

  // Failure count after this rejection; it never climbs past MAX_TRIES.
  assign err_inc = (err_cnt >= MAX_T) ? MAX_T : err_cnt + 3'd1;

  // Next-state logic. Within a cycle cancel beats enter, and enter beats key_valid.
  always_comb begin
    state_n = state;
    digit_n = digit_cnt;
    mism_n  = mismatch;
    err_n   = err_cnt;
    timer_n = timer;
    case (state)
      IDLE: begin
        if (cancel) begin
          state_n = IDLE;
        end else if (enter) begin
          state_n = FAIL;
        end else if (key_valid) begin
          mism_n  = (key_digit != exp_digit);
          digit_n = 3'd1;
          state_n = ENTRY;
        end
      end
      ENTRY: begin
        if (cancel) begin
          state_n = IDLE;
          digit_n = 3'd0;
          mism_n  = 1'b0;
        end else if (enter) begin
          if (digit_cnt == 3'd6 && !mismatch) begin
            state_n = OPEN;
            err_n   = 3'd0;
            digit_n = 3'd0;
            mism_n  = 1'b0;
            timer_n = TW'(UNLOCK_CYCLES - 1);
          end else begin
            state_n = FAIL;
          end
        end else if (key_valid) begin
          if (digit_cnt < 3'd6) begin
            mism_n  = mismatch | (key_digit != exp_digit);
            digit_n = digit_cnt + 3'd1;
          end else begin
            // An overlong entry can never match.
            mism_n = 1'b1;
          end
        end
      end
      OPEN: begin
        if (timer == '0) state_n = IDLE;
        else             timer_n = timer - 1'b1;
      end
      FAIL: begin
        err_n   = err_inc;
        digit_n = 3'd0;
        mism_n  = 1'b0;
        if (err_inc == MAX_T) begin
          state_n = ALARM;
          timer_n = TW'(ALARM_CYCLES - 1);
        end else begin
          state_n = IDLE;
        end
      end
      ALARM: begin
        if (timer == '0) begin
          state_n = IDLE;
          err_n   = 3'd0;
        end else begin
          timer_n = timer - 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and datapath registers. The outputs are flopped from the next
  // state, so each one follows its state with no input-to-output path.
  always_ff @(posedge clk) begin
    if (clr) begin
      state     <= IDLE;
      digit_cnt <= 3'd0;
      err_cnt   <= 3'd0;
      mismatch  <= 1'b0;
      timer     <= '0;
      unlock    <= 1'b0;
      fail      <= 1'b0;
      alarm     <= 1'b0;
    end else begin
      state     <= state_n;
      digit_cnt <= digit_n;
      err_cnt   <= err_n;
      mismatch  <= mism_n;
      timer     <= timer_n;
      unlock    <= (state_n == OPEN);
      fail      <= (state_n == FAIL);
      alarm     <= (state_n == ALARM);
    end
  end

endmodule

// File: tb/tb_passwd_checker.sv
// Directed bench for passwd_checker: hand-computed expectations, sampled 1ns after each rising edge.
module tb_passwd_checker;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       key_valid = 1'b0;
  logic [3:0] key_digit = 4'd0;
  logic       enter = 1'b0;
  logic       cancel = 1'b0;
  logic [3:0] q1 = 4'd1, q2 = 4'd2, q3 = 4'd3, q4 = 4'd4, q5 = 4'd5, q6 = 4'd6;
  logic       unlock, fail, alarm;
  logic [2:0] digit_cnt, err_cnt;

  int n_vec = 0;
  int n_err = 0;

  passwd_checker #(.MAX_TRIES(3), .UNLOCK_CYCLES(16), .ALARM_CYCLES(32)) dut (
    .clk(clk), .clr(clr), .key_valid(key_valid), .key_digit(key_digit),
    .enter(enter), .cancel(cancel),
    .q1(q1), .q2(q2), .q3(q3), .q4(q4), .q5(q5), .q6(q6),
    .unlock(unlock), .fail(fail), .alarm(alarm),
    .digit_cnt(digit_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] d);
    key_valid = 1'b1; key_digit = d;
    tick();
    key_valid = 1'b0;
  endtask

  task automatic do_enter();
    enter = 1'b1;
    tick();
    enter = 1'b0;
  endtask

  task automatic do_cancel();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
  endtask

  task automatic do_reset();
    clr = 1'b1;
    tick(); tick();
    clr = 1'b0;
  endtask

  task automatic good_digits();
    for (int i = 1; i <= 6; i++) press(4'(i));
  endtask

  // One-digit wrong entry, leaving the sample point on the cycle after FAIL.
  task automatic wrong_entry();
    press(4'd9);
    do_enter();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    logic saw_unlock, saw_digit;

    // Reset state
    do_reset();
    check("rst_unlock", unlock, 0);
    check("rst_fail", fail, 0);
    check("rst_alarm", alarm, 0);
    check("rst_digit", digit_cnt, 0);
    check("rst_err", err_cnt, 0);

    // Correct entry: digit count steps, 16-cycle unlock
    for (int i = 1; i <= 6; i++) begin
      press(4'(i));
      check($sformatf("ok_digit%0d", i), digit_cnt, i);
    end
    do_enter();
    check("ok_unlock_first", unlock, 1);
    check("ok_fail", fail, 0);
    check("ok_digit_clr", digit_cnt, 0);
    cnt = 0;
    while (unlock && cnt < 100) begin cnt++; tick(); end
    check("ok_unlock_len", cnt, 16);
    check("ok_err", err_cnt, 0);

    // Wrong third digit
    press(4'd1); press(4'd2); press(4'd9); press(4'd4); press(4'd5); press(4'd6);
    do_enter();
    check("wr_fail_pulse", fail, 1);
    check("wr_unlock", unlock, 0);
    tick();
    check("wr_fail_end", fail, 0);
    check("wr_err", err_cnt, 1);
    check("wr_digit", digit_cnt, 0);
    check("wr_unlock2", unlock, 0);

    // Short then long entry
    do_reset();
    for (int i = 1; i <= 5; i++) press(4'(i));
    do_enter();
    check("short_fail", fail, 1);
    tick();
    check("short_err", err_cnt, 1);
    good_digits();
    press(4'd7);
    check("long_digit_sat", digit_cnt, 6);
    do_enter();
    check("long_fail", fail, 1);
    check("long_unlock", unlock, 0);
    tick();
    check("long_err", err_cnt, 2);

    // Lockout after three failures; entry during alarm ignored
    do_reset();
    wrong_entry();
    wrong_entry();
    check("lk_err2", err_cnt, 2);
    check("lk_noalarm", alarm, 0);
    press(4'd9);
    do_enter();
    check("lk_fail3", fail, 1);
    tick();
    check("lk_alarm_on", alarm, 1);
    check("lk_fail_off", fail, 0);
    check("lk_err3", err_cnt, 3);
    cnt = 0; saw_unlock = 1'b0; saw_digit = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (alarm) cnt++;
      if (unlock) saw_unlock = 1'b1;
      if (digit_cnt != 3'd0) saw_digit = 1'b1;
      if (c < 6) begin key_valid = 1'b1; key_digit = 4'(c + 1); end
      else if (c == 6) enter = 1'b1;
      else if (c == 7) cancel = 1'b1;
      tick();
      key_valid = 1'b0; enter = 1'b0; cancel = 1'b0;
    end
    check("lk_alarm_len", cnt, 32);
    check("lk_no_unlock", saw_unlock, 0);
    check("lk_no_digits", saw_digit, 0);
    check("lk_err_clr", err_cnt, 0);
    good_digits();
    do_enter();
    check("lk_after_unlock", unlock, 1);
    for (int i = 0; i < 16; i++) tick();
    check("lk_after_idle", unlock, 0);

    // Cancel and strobe priority
    wrong_entry();
    press(4'd1); press(4'd2); press(4'd3);
    check("cn_digit3", digit_cnt, 3);
    do_cancel();
    check("cn_digit0", digit_cnt, 0);
    check("cn_err_keep", err_cnt, 1);
    cancel = 1'b1; enter = 1'b1;
    tick();
    cancel = 1'b0; enter = 1'b0;
    check("cn_idle_no_fail", fail, 0);
    press(4'd1);
    cancel = 1'b1; enter = 1'b1;
    tick();
    cancel = 1'b0; enter = 1'b0;
    check("cn_entry_no_fail", fail, 0);
    check("cn_entry_digit", digit_cnt, 0);
    press(4'd9);
    do_cancel();
    good_digits();
    do_enter();
    check("cn_mism_cleared", unlock, 1);
    check("cn_open_err_clr", err_cnt, 0);
    for (int i = 0; i < 16; i++) tick();
    for (int i = 1; i <= 5; i++) press(4'(i));
    enter = 1'b1; key_valid = 1'b1; key_digit = 4'd6;
    tick();
    enter = 1'b0; key_valid = 1'b0;
    check("pr_key_dropped_fail", fail, 1);
    check("pr_key_dropped_cnt", digit_cnt, 5);
    tick();

    // q changes mid-entry; digits 10-15 compared as-is
    do_reset();
    press(4'd1); press(4'd2);
    q3 = 4'd7;
    press(4'd7); press(4'd4); press(4'd5);
    q6 = 4'hC;
    press(4'hC);
    do_enter();
    check("qchg_unlock", unlock, 1);
    q3 = 4'd3; q6 = 4'd6;

    // Reset during OPEN cycle 5
    do_reset();
    good_digits();
    do_enter();
    for (int i = 0; i < 4; i++) tick();
    check("ro_open5", unlock, 1);
    clr = 1'b1; tick(); clr = 1'b0;
    check("ro_unlock", unlock, 0);
    check("ro_digit", digit_cnt, 0);
    check("ro_err", err_cnt, 0);
    press(4'd1);
    check("ro_idle_key", digit_cnt, 1);
    check("ro_still_locked", unlock, 0);
    do_cancel();

    // Reset during ALARM cycle 10
    wrong_entry(); wrong_entry(); wrong_entry();
    check("ra_alarm1", alarm, 1);
    for (int i = 0; i < 9; i++) tick();
    check("ra_alarm10", alarm, 1);
    clr = 1'b1; tick(); clr = 1'b0;
    check("ra_alarm", alarm, 0);
    check("ra_err", err_cnt, 0);
    check("ra_digit", digit_cnt, 0);
    check("ra_unlock", unlock, 0);
    good_digits();
    do_enter();
    check("ra_idle_unlock", unlock, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
